// File: rtl/bcd_result_splitter.sv
// Binary-to-BCD converter for the seven-segment path: iterative double-dabble, one bit per clock.
// Produces packed digits, a leading-zero blank mask and a display-overflow flag.
module bcd_result_splitter #(
  parameter int WIDTH       = 16,
  parameter int DIGITS      = 5,
  parameter int SHOW_DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      value,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]     blank,
  output logic                  overflow
);

  localparam int              CW        = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]   LAST      = CW'(WIDTH - 1);
  localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t              state, state_nxt;
  logic [4*DIGITS-1:0] work, adj;
  logic [WIDTH-1:0]    operand;
  logic [CW-1:0]       cnt;
  logic [DIGITS-1:0]   blank_nxt;
  logic                ovf_nxt;
  logic                hi_zero;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_SHIFT;
      S_SHIFT: if (cnt == LAST) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != S_IDLE);
  end

  // Add-3 correction happens before the shift so each digit stays within 0..9 afterwards.
  always_comb begin
    adj = work;
    for (int i = 0; i < DIGITS; i++) begin
      if (work[4*i +: 4] >= 4'd5) adj[4*i +: 4] = work[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    blank_nxt = '0;
    hi_zero   = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      hi_zero      = hi_zero & (work[4*i +: 4] == 4'd0);
      blank_nxt[i] = hi_zero;
    end
  end

  always_comb begin
    ovf_nxt = 1'b0;
    for (int i = SHOW_DIGITS; i < DIGITS; i++) begin
      ovf_nxt = ovf_nxt | (work[4*i +: 4] != 4'd0);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      work     <= '0;
      operand  <= '0;
      cnt      <= '0;
      bcd      <= '0;
      blank    <= BLANK_RST;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            operand <= value;
            work    <= '0;
            cnt     <= '0;
          end
        end
        S_SHIFT: begin
          work    <= {adj[4*DIGITS-2:0], operand[WIDTH-1]};
          operand <= operand << 1;
          cnt     <= cnt + 1'b1;
        end
        S_DONE: begin
          bcd      <= work;
          blank    <= blank_nxt;
          overflow <= ovf_nxt;
          done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_result_splitter.sv
// Directed bench for bcd_result_splitter: hand-computed digit, blank and overflow results.
module tb_bcd_result_splitter;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] value;
  logic        busy;
  logic        done;
  logic [19:0] bcd;
  logic [4:0]  blank;
  logic        overflow;

  int tests;
  int failed;
  int done_cnt;
  int d0;

  bcd_result_splitter #(.WIDTH(16), .DIGITS(5), .SHOW_DIGITS(3)) dut (
    .clk(clk), .reset(reset), .start(start), .value(value),
    .busy(busy), .done(done), .bcd(bcd), .blank(blank), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives start with v so it is sampled at the next edge (E0); returns #1 after E0.
  task automatic pulse_start(input logic [15:0] v);
    start = 1'b1;
    value = v;
    @(posedge clk);
    #1;
    start = 1'b0;
    value = ~v;
    check("busy_after_start", {31'd0, busy}, 32'd1);
  endtask

  // Runs from #1 after edge E<n> through E18 and checks the result window.
  task automatic finish_conv(input string tag, input int n, input logic [19:0] prev,
                             input logic [19:0] exp_bcd, input logic [4:0] exp_blank,
                             input logic exp_ovf);
    repeat (16 - n) @(posedge clk);
    #1;
    check({tag, "_busy_e16"}, {31'd0, busy}, 32'd1);
    check({tag, "_done_e16"}, {31'd0, done}, 32'd0);
    check({tag, "_bcd_hold"}, {12'd0, bcd}, {12'd0, prev});
    @(posedge clk);
    #1;
    check({tag, "_done_e17"}, {31'd0, done}, 32'd1);
    check({tag, "_busy_e17"}, {31'd0, busy}, 32'd0);
    check({tag, "_bcd"}, {12'd0, bcd}, {12'd0, exp_bcd});
    check({tag, "_blank"}, {27'd0, blank}, {27'd0, exp_blank});
    check({tag, "_ovf"}, {31'd0, overflow}, {31'd0, exp_ovf});
    @(posedge clk);
    #1;
    check({tag, "_done_e18"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    tests = 0; failed = 0; done_cnt = 0;
    reset = 1'b0; start = 1'b0; value = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_bcd", {12'd0, bcd}, 32'd0);
    check("rst_blank", {27'd0, blank}, 32'h1E);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("idle_busy", {31'd0, busy}, 32'd0);

    // 1: zero
    pulse_start(16'd0);
    finish_conv("t1_zero", 0, 20'h00000, 20'h00000, 5'b11110, 1'b0);

    // 2: 42
    d0 = done_cnt;
    pulse_start(16'd42);
    finish_conv("t2_42", 0, 20'h00000, 20'h00042, 5'b11100, 1'b0);
    check("t2_one_done", done_cnt - d0, 32'd1);

    // 3: display boundary
    pulse_start(16'd999);
    finish_conv("t3_999", 0, 20'h00042, 20'h00999, 5'b11000, 1'b0);
    pulse_start(16'd1000);
    finish_conv("t3_1000", 0, 20'h00999, 20'h01000, 5'b10000, 1'b1);

    // 4: all ones
    pulse_start(16'd65535);
    finish_conv("t4_max", 0, 20'h01000, 20'h65535, 5'b00000, 1'b1);

    // 5: start while busy is ignored
    d0 = done_cnt;
    pulse_start(16'd123);
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1;
    value = 16'd777;
    @(posedge clk);
    #1;
    start = 1'b0;
    finish_conv("t5_ignore", 5, 20'h65535, 20'h00123, 5'b11000, 1'b0);
    check("t5_one_done", done_cnt - d0, 32'd1);
    repeat (20) @(posedge clk);
    #1;
    check("t5_no_queued_done", done_cnt - d0, 32'd1);
    check("t5_bcd_kept", {12'd0, bcd}, 32'h00123);

    // 6: reset mid-conversion
    d0 = done_cnt;
    pulse_start(16'd500);
    repeat (7) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("t6_busy", {31'd0, busy}, 32'd0);
    check("t6_done", {31'd0, done}, 32'd0);
    check("t6_bcd", {12'd0, bcd}, 32'd0);
    check("t6_blank", {27'd0, blank}, 32'h1E);
    @(negedge clk);
    reset = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("t6_no_done", done_cnt - d0, 32'd0);
    check("t6_idle", {31'd0, busy}, 32'd0);
    pulse_start(16'd7);
    finish_conv("t6_7", 0, 20'h00000, 20'h00007, 5'b11110, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
